// File: rtl/oled_pkg.sv
// Shared SSD1306 constants, frame geometry, addressing command list and FSM states
// for the OLED SPI streamer.
package oled_pkg;

    localparam int FRAME_BYTES = 1024;
    localparam int INIT_LEN    = 25;
    localparam int ADDR_LEN    = 6;

    localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] CMD_COL_ADDR    = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] CMD_NOP         = 8'hE3;

    typedef enum logic [2:0] {
        ST_RST_PULSE,
        ST_PWR_WAIT,
        ST_INIT,
        ST_ADDR,
        ST_FETCH,
        ST_DATA,
        ST_FRAME_END
    } oled_state_t;

    // Full-screen window: columns 0..127, pages 0..7.
    function automatic logic [7:0] addr_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = CMD_COL_ADDR;
            3'd1:    cmd = 8'h00;
            3'd2:    cmd = 8'h7F;
            3'd3:    cmd = CMD_PAGE_ADDR;
            3'd4:    cmd = 8'h00;
            3'd5:    cmd = 8'h07;
            default: cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-on initialisation command table, 25 entries, purely combinational.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [4:0] index,
    output logic [7:0] cmd
);

    always_comb begin
        cmd = CMD_NOP;
        case (index)
            5'd0:  cmd = CMD_DISPLAY_OFF;
            5'd1:  cmd = 8'hD5;
            5'd2:  cmd = 8'h80;
            5'd3:  cmd = 8'hA8;
            5'd4:  cmd = 8'h3F;
            5'd5:  cmd = 8'hD3;
            5'd6:  cmd = 8'h00;
            5'd7:  cmd = 8'h40;
            5'd8:  cmd = 8'h8D;
            5'd9:  cmd = 8'h14;
            5'd10: cmd = 8'h20;
            5'd11: cmd = 8'h00;
            5'd12: cmd = 8'hA1;
            5'd13: cmd = 8'hC8;
            5'd14: cmd = 8'hDA;
            5'd15: cmd = 8'h12;
            5'd16: cmd = 8'h81;
            5'd17: cmd = 8'hCF;
            5'd18: cmd = 8'hD9;
            5'd19: cmd = 8'hF1;
            5'd20: cmd = 8'hDB;
            5'd21: cmd = 8'h40;
            5'd22: cmd = 8'hA4;
            5'd23: cmd = 8'hA6;
            5'd24: cmd = CMD_DISPLAY_ON;
            default: cmd = CMD_NOP;
        endcase
    end

endmodule

// File: rtl/oled_spi_streamer.sv
// SSD1306 128x64 OLED driver over 4-wire SPI: reset pulse, power-up wait, init, endless refresh.
// Build option OLED_TEST_PATTERN_EN replaces framebuffer data with an AA/55 checkerboard.
module oled_spi_streamer
    import oled_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int RESET_CYCLES   = 1000,
    parameter int POWERUP_CYCLES = 100000,
    parameter int FETCH_LAT      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] byte_counter,
    input  logic [7:0] data_to_send,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic       frame_done,
    output logic       init_done
);

    localparam int DLY_MAX = (RESET_CYCLES > POWERUP_CYCLES) ? RESET_CYCLES : POWERUP_CYCLES;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FL_W    = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

    localparam logic [DLY_W-1:0] RST_LAST   = DLY_W'(RESET_CYCLES - 1);
    localparam logic [DLY_W-1:0] PWR_LAST   = DLY_W'(POWERUP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [FL_W-1:0]  FETCH_LAST = FL_W'(FETCH_LAT - 1);
    localparam logic [9:0]       LAST_BYTE  = 10'(FRAME_BYTES - 1);

    oled_state_t      state, state_next;
    logic [DLY_W-1:0] delay_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [FL_W-1:0]  fetch_cnt;
    logic [2:0]       bit_cnt;
    logic [4:0]       cmd_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       data_latch;
    logic [7:0]       rom_cmd;
    logic [7:0]       tx_byte;
    logic [7:0]       fetch_byte;
    logic             sclk_q;
    logic             shifting;
    logic             init_q;
    logic             byte_state;
    logic             byte_done;

    oled_init_rom u_init_rom (
        .index (cmd_idx),
        .cmd   (rom_cmd)
    );

`ifdef OLED_TEST_PATTERN_EN
    assign fetch_byte = byte_counter[0] ? 8'h55 : 8'hAA;
`else
    assign fetch_byte = data_to_send;
`endif

    assign byte_state = (state == ST_INIT) || (state == ST_ADDR) || (state == ST_DATA);
    // Last clk of the high half of bit0: the byte's final edge.
    assign byte_done  = shifting && sclk_q && (div_cnt == DIV_LAST) && (bit_cnt == 3'd0);

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            ST_INIT: tx_byte = rom_cmd;
            ST_ADDR: tx_byte = addr_cmd(cmd_idx[2:0]);
            ST_DATA: tx_byte = data_latch;
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RST_PULSE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        oled_res_n = (state != ST_RST_PULSE);
        oled_dc    = (state == ST_DATA);
        frame_done = (state == ST_FRAME_END);
        case (state)
            ST_RST_PULSE: if (delay_cnt == RST_LAST) state_next = ST_PWR_WAIT;
            ST_PWR_WAIT:  if (delay_cnt == PWR_LAST) state_next = ST_INIT;
            ST_INIT:      if (byte_done && cmd_idx == 5'(INIT_LEN - 1)) state_next = ST_ADDR;
            ST_ADDR:      if (byte_done && cmd_idx == 5'(ADDR_LEN - 1)) state_next = ST_FETCH;
            ST_FETCH:     if (fetch_cnt == FETCH_LAST) state_next = ST_DATA;
            ST_DATA:      if (byte_done) state_next = (byte_counter == LAST_BYTE) ? ST_FRAME_END : ST_FETCH;
            ST_FRAME_END: state_next = ST_ADDR;
            default:      state_next = ST_RST_PULSE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_cnt    <= '0;
            fetch_cnt    <= '0;
            cmd_idx      <= '0;
            data_latch   <= '0;
            byte_counter <= '0;
            init_q       <= 1'b0;
        end else begin
            if ((state == ST_RST_PULSE || state == ST_PWR_WAIT) && state_next == state)
                delay_cnt <= delay_cnt + 1'b1;
            else
                delay_cnt <= '0;

            if (state_next != state) cmd_idx <= '0;
            else if (byte_done)      cmd_idx <= cmd_idx + 1'b1;

            if (state == ST_FETCH && state_next == ST_FETCH) fetch_cnt <= fetch_cnt + 1'b1;
            else                                             fetch_cnt <= '0;

            if (state == ST_FETCH && state_next == ST_DATA) data_latch <= fetch_byte;

            if (state == ST_DATA && state_next == ST_FETCH)  byte_counter <= byte_counter + 1'b1;
            else if (state_next == ST_FRAME_END)             byte_counter <= '0;

            if (state_next == ST_ADDR) init_q <= 1'b1;
        end
    end

    // Byte engine: CLK_DIV setup clks with cs_n high (dc already valid, doubles as the
    // inter-byte gap), then 8 bits of CLK_DIV low + CLK_DIV high with cs_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sclk_q    <= 1'b0;
            shifting  <= 1'b0;
        end else if (!byte_state) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
            shifting <= 1'b0;
        end else if (!shifting) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                shifting  <= 1'b1;
                bit_cnt   <= 3'd7;
                shift_reg <= tx_byte;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
            if (sclk_q) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                if (bit_cnt == 3'd0) shifting <= 1'b0;
                else                 bit_cnt  <= bit_cnt - 1'b1;
            end
        end
    end

    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = ~shifting;
    assign spi_mosi  = shift_reg[7];
    assign init_done = init_q;

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Self-checking bench for oled_spi_streamer: SPI byte monitor, table-driven command checks,
// full-frame data checks, and a mid-byte asynchronous reset (honours OLED_TEST_PATTERN_EN).
`timescale 1ns/1ps
module tb_oled_spi_streamer;

    localparam int CLK_DIV        = 2;
    localparam int RESET_CYCLES   = 10;
    localparam int POWERUP_CYCLES = 20;
    localparam int FETCH_LAT      = 2;
    localparam int MAX_GAP        = 2 * (17 * CLK_DIV + FETCH_LAT);

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       init;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       init;
        logic [9:0] bc;
        int         cyc;
        logic       ok;
    } rx_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] byte_counter;
    logic [7:0] data_to_send = 8'h00;
    logic       spi_sclk, spi_mosi, spi_cs_n, oled_dc, oled_res_n, frame_done, init_done;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   last_cyc = 0;
    int   fd_count = 0;
    logic fd_wide = 1'b0;
    logic fd_prev = 1'b0;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    vec_t       tbl[31];
    logic [7:0] init_bytes[25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                   8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                   8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] addr_bytes[6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    oled_spi_streamer #(
        .CLK_DIV        (CLK_DIV),
        .RESET_CYCLES   (RESET_CYCLES),
        .POWERUP_CYCLES (POWERUP_CYCLES),
        .FETCH_LAT      (FETCH_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_counter (byte_counter),
        .data_to_send (data_to_send),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .oled_dc      (oled_dc),
        .oled_res_n   (oled_res_n),
        .frame_done   (frame_done),
        .init_done    (init_done)
    );

    // Clock/reset block
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Framebuffer model: answers with byte_counter[7:0] one clk after byte_counter changes.
    initial begin
        logic [7:0] prev;
        prev = 8'h00;
        forever begin
            @(posedge clk);
            #1;
`ifdef OLED_TEST_PATTERN_EN
            data_to_send = 8'hFF;
`else
            data_to_send = prev;
            prev = byte_counter[7:0];
`endif
        end
    end

    // SPI monitor: rebuilds bytes on sclk rising edges; flags bit count, dc and mosi stability.
    initial begin
        logic       prev_cs, prev_sclk, prev_mosi, f_dc, f_init, bad;
        logic [7:0] sr;
        logic [9:0] f_bc;
        int         bits, f_cyc;
        rx_t        r;
        prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; bad = 1'b0;
        f_dc = 1'b0; f_init = 1'b0; f_bc = '0; sr = '0; bits = 0; f_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cs = 1'b1; prev_sclk = 1'b0; bits = 0;
            end else begin
                if (prev_cs && !spi_cs_n) begin
                    bits = 0; sr = '0; bad = 1'b0;
                    f_cyc = cyc; f_dc = oled_dc; f_init = init_done; f_bc = byte_counter;
                end
                if (!spi_cs_n && spi_sclk && !prev_sclk) begin
                    sr = {sr[6:0], spi_mosi};
                    bits++;
                end
                if (!spi_cs_n && oled_dc !== f_dc) bad = 1'b1;
                if (!spi_cs_n && spi_sclk && prev_sclk && spi_mosi !== prev_mosi) bad = 1'b1;
                if (!prev_cs && spi_cs_n) begin
                    r.data = sr; r.dc = f_dc; r.init = f_init; r.bc = f_bc; r.cyc = f_cyc;
                    r.ok = (bits == 8) && !bad;
                    rx_q.push_back(r);
                end
                prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_mosi = spi_mosi;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (frame_done) begin
            fd_count++;
            if (fd_prev) fd_wide = 1'b1;
        end
        fd_prev = frame_done;
    end

    // Scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic get_byte(output rx_t r);
        int n;
        n = 0;
        while (rx_q.size() == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL spi_timeout: no byte within %0d clk", n);
            r.data = '0; r.dc = 1'b0; r.init = 1'b0; r.bc = '0; r.cyc = cyc; r.ok = 1'b0;
        end else begin
            r = rx_q.pop_front();
        end
    endtask

    task automatic release_reset();
        int cnt;
        @(negedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            cnt++;
            #1;
            if (oled_res_n) break;
        end
        rise_cyc = cyc;
        check("res_n_low_clks", cnt, RESET_CYCLES);
    endtask

    function automatic logic [7:0] exp_data(input int idx);
`ifdef OLED_TEST_PATTERN_EN
        return idx[0] ? 8'h55 : 8'hAA;
`else
        return idx[7:0];
`endif
    endfunction

    task automatic data_bytes(input int n_bytes);
        rx_t r;
        for (int i = 0; i < n_bytes; i++) begin
            exp_q.push_back(exp_data(i));
            get_byte(r);
            check("data_byte", r.data, exp_q.pop_front());
            check("data_bc", r.bc, i);
            if (r.dc !== 1'b1 || !r.ok) check("data_dc_framing", {r.dc, r.ok}, 2'b11);
            if (r.cyc - last_cyc > MAX_GAP) check("data_gap_ok", r.cyc - last_cyc, MAX_GAP);
            last_cyc = r.cyc;
        end
    endtask

    task automatic cmd_bytes(input int first, input int last);
        rx_t r;
        for (int i = first; i <= last; i++) begin
            get_byte(r);
            check("cmd_byte", r.data, tbl[i].data);
            check("cmd_dc", r.dc, tbl[i].dc);
            check("cmd_init_done", r.init, tbl[i].init);
            check("cmd_framing", r.ok, 1'b1);
            if (i == 0) check("powerup_wait_ok", (r.cyc - rise_cyc) >= POWERUP_CYCLES, 1'b1);
            else if (r.cyc - last_cyc > MAX_GAP) check("cmd_gap_ok", r.cyc - last_cyc, MAX_GAP);
            last_cyc = r.cyc;
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 25; i++) tbl[i] = '{data: init_bytes[i], dc: 1'b0, init: 1'b0};
        for (int i = 0; i < 6; i++)  tbl[25 + i] = '{data: addr_bytes[i], dc: 1'b0, init: 1'b1};

        repeat (3) @(negedge clk);
        check("rst_byte_counter", byte_counter, 10'd0);
        check("rst_spi_pins", {spi_sclk, spi_mosi, spi_cs_n}, 3'b001);
        check("rst_dc_res", {oled_dc, oled_res_n}, 2'b00);
        check("rst_flags", {frame_done, init_done}, 2'b00);

        release_reset();
        cmd_bytes(0, 30);
        data_bytes(1024);
        cmd_bytes(25, 30);
        check("frame_done_count", fd_count, 1);
        check("frame_done_one_clk", fd_wide, 1'b0);
        data_bytes(500);

        n = 0;
        while (spi_cs_n && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cs_fall_byte500", spi_cs_n, 1'b0);
        check("bc_byte500", byte_counter, 10'd500);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pins", {spi_cs_n, spi_sclk, oled_res_n}, 3'b100);
        check("async_rst_state", {byte_counter, init_done, oled_dc}, 12'd0);
        repeat (4) @(negedge clk);
        rx_q.delete();
        release_reset();
        cmd_bytes(0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
